// File: rtl/soc_pkg.sv
// Shared definitions for the RAM arbiter: bus widths, state encoding and
// the tie-break helper used when both masters request in the same cycle.
package soc_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_GRANT0 = ST_GRANT0,
        S_GRANT1 = ST_GRANT1
    } arb_state_t;

    // Returns 1 when master 1 should be granted. A lone requester always
    // wins; on a tie the priority bit decides (0 = master 0, 1 = master 1).
    function automatic logic pick_master(input logic v0, input logic v1, input logic prio);
        logic sel;
        if (v0 && v1) begin
            sel = prio;
        end else begin
            sel = v1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-master to one-slave arbiter in front of the system RAM.
// One master is granted per transaction; the grant is held until the RAM
// returns ready, then a single IDLE cycle separates it from the next grant.
import soc_pkg::*;

module ram_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_address,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wsel,
    input  logic        m0_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_error,

    input  logic [31:0] m1_address,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wsel,
    input  logic        m1_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_error,

    output logic [31:0] ram_address,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wsel,
    output logic        ram_valid,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,
    input  logic        ram_error
);

    arb_state_t state;
    logic       prio;
    logic       prio_eff;

    // Fixed-priority mode ignores the register and always favours master 1.
    assign prio_eff = (ROUND_ROBIN != 0) ? prio : 1'b1;

    // Grant FSM and round-robin priority; a completed transfer hands
    // priority to the master that was just waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            prio  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        if (pick_master(m0_valid, m1_valid, prio_eff)) begin
                            state <= S_GRANT1;
                        end else begin
                            state <= S_GRANT0;
                        end
                    end
                end
                S_GRANT0: begin
                    if (ram_ready) begin
                        state <= S_IDLE;
                        if (ROUND_ROBIN != 0) begin
                            prio <= 1'b1;
                        end
                    end
                end
                S_GRANT1: begin
                    if (ram_ready) begin
                        state <= S_IDLE;
                        if (ROUND_ROBIN != 0) begin
                            prio <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Request/response mux: the granted master sees the RAM directly,
    // everything else is held at zero. A master dropping valid mid-grant
    // pulls ram_valid low, but the grant persists until the RAM answers.
    always_comb begin
        ram_address = '0;
        ram_wdata   = '0;
        ram_wsel    = '0;
        ram_valid   = 1'b0;
        m0_rdata    = '0;
        m0_ready    = 1'b0;
        m0_error    = 1'b0;
        m1_rdata    = '0;
        m1_ready    = 1'b0;
        m1_error    = 1'b0;
        case (state)
            S_GRANT0: begin
                ram_address = m0_address;
                ram_wdata   = m0_wdata;
                ram_wsel    = m0_wsel;
                ram_valid   = m0_valid;
                m0_rdata    = ram_rdata;
                m0_ready    = ram_ready;
                m0_error    = ram_error;
            end
            S_GRANT1: begin
                ram_address = m1_address;
                ram_wdata   = m1_wdata;
                ram_wsel    = m1_wsel;
                ram_valid   = m1_valid;
                m1_rdata    = ram_rdata;
                m1_ready    = ram_ready;
                m1_error    = ram_error;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin instance backed by a small RAM model
// (4 KiB, accesses above it answer with error) and a fixed-priority instance
// backed by a data-less responder. Expected responses are queued per master
// at issue time from a reference memory and checked by a monitor on ready.
module tb_ram_arbiter;
    import soc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] m0_address, m0_wdata, m0_rdata;
    logic [3:0]  m0_wsel;
    logic        m0_valid, m0_ready, m0_error;
    logic [31:0] m1_address, m1_wdata, m1_rdata;
    logic [3:0]  m1_wsel;
    logic        m1_valid, m1_ready, m1_error;
    logic [31:0] ram_address, ram_wdata, ram_rdata;
    logic [3:0]  ram_wsel;
    logic        ram_valid, ram_ready, ram_error;

    logic [31:0] f_m0_address, f_m0_wdata, f_m0_rdata;
    logic [3:0]  f_m0_wsel;
    logic        f_m0_valid, f_m0_ready, f_m0_error;
    logic [31:0] f_m1_address, f_m1_wdata, f_m1_rdata;
    logic [3:0]  f_m1_wsel;
    logic        f_m1_valid, f_m1_ready, f_m1_error;
    logic [31:0] f_ram_address, f_ram_wdata, f_ram_rdata;
    logic [3:0]  f_ram_wsel;
    logic        f_ram_valid, f_ram_ready, f_ram_error;

    ram_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_wsel(m0_wsel), .m0_valid(m0_valid),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
        .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_wsel(m1_wsel), .m1_valid(m1_valid),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
        .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_wsel(ram_wsel), .ram_valid(ram_valid),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready), .ram_error(ram_error)
    );

    ram_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst(rst),
        .m0_address(f_m0_address), .m0_wdata(f_m0_wdata), .m0_wsel(f_m0_wsel), .m0_valid(f_m0_valid),
        .m0_rdata(f_m0_rdata), .m0_ready(f_m0_ready), .m0_error(f_m0_error),
        .m1_address(f_m1_address), .m1_wdata(f_m1_wdata), .m1_wsel(f_m1_wsel), .m1_valid(f_m1_valid),
        .m1_rdata(f_m1_rdata), .m1_ready(f_m1_ready), .m1_error(f_m1_error),
        .ram_address(f_ram_address), .ram_wdata(f_ram_wdata), .ram_wsel(f_ram_wsel), .ram_valid(f_ram_valid),
        .ram_rdata(f_ram_rdata), .ram_ready(f_ram_ready), .ram_error(f_ram_error)
    );

    // RAM model (RAM_AW=12): sees valid, spends one busy cycle, then pulses
    // ready with the access committed. Reset clears contents.
    logic [31:0] mem [0:1023];
    logic        ram_busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ready <= 1'b0;
            ram_error <= 1'b0;
            ram_rdata <= 32'h0;
            ram_busy  <= 1'b0;
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (ram_ready) begin
            ram_ready <= 1'b0;
            ram_error <= 1'b0;
            ram_busy  <= 1'b0;
        end else if (ram_valid && !ram_busy) begin
            ram_busy <= 1'b1;
        end else if (ram_valid && ram_busy) begin
            ram_busy  <= 1'b0;
            ram_ready <= 1'b1;
            if (ram_address[31:12] != 20'h0) begin
                ram_error <= 1'b1;
                ram_rdata <= 32'h0;
            end else begin
                ram_error <= 1'b0;
                ram_rdata <= mem[ram_address[11:2]];
                for (int b = 0; b < 4; b++)
                    if (ram_wsel[b]) mem[ram_address[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end else begin
            ram_busy <= 1'b0;
        end
    end

    // Responder for the fixed-priority instance, same timing, no storage.
    logic f_busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f_ram_ready <= 1'b0;
            f_ram_error <= 1'b0;
            f_ram_rdata <= 32'h0;
            f_busy      <= 1'b0;
        end else if (f_ram_ready) begin
            f_ram_ready <= 1'b0;
            f_busy      <= 1'b0;
        end else if (f_ram_valid && !f_busy) begin
            f_busy <= 1'b1;
        end else if (f_ram_valid && f_busy) begin
            f_busy      <= 1'b0;
            f_ram_ready <= 1'b1;
            f_ram_rdata <= f_ram_address ^ 32'hA5A5_0000;
        end else begin
            f_busy <= 1'b0;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          serve_log[$];
    logic [31:0] ref_mem [0:1023];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Monitor: pops the expected response on each ready and checks the
    // cross-master and idle-bus rules every cycle.
    logic prev_r0 = 1'b0;
    logic prev_r1 = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_ready) begin
                serve_log.push_back(0);
                if (q0.size() == 0) begin
                    fail_now("m0_unexpected_ready", "ready=1 with no outstanding request");
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    if (e.chk) check("m0_rdata", m0_rdata, e.rdata);
                    check("m0_error", {31'h0, m0_error}, {31'h0, e.err});
                end
                check("m0_ready_single_pulse", {31'h0, prev_r0}, 32'h0);
            end
            if (m1_ready) begin
                serve_log.push_back(1);
                if (q1.size() == 0) begin
                    fail_now("m1_unexpected_ready", "ready=1 with no outstanding request");
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    if (e.chk) check("m1_rdata", m1_rdata, e.rdata);
                    check("m1_error", {31'h0, m1_error}, {31'h0, e.err});
                end
                check("m1_ready_single_pulse", {31'h0, prev_r1}, 32'h0);
            end
            if (m0_ready && m1_ready) fail_now("ready_exclusive", "m0_ready and m1_ready both 1");
            if (!ram_valid) begin
                check("idle_ram_address", ram_address, 32'h0);
                check("idle_ram_wdata_wsel", ram_wdata | {28'h0, ram_wsel}, 32'h0);
            end
        end
        prev_r0 <= m0_ready;
        prev_r1 <= m1_ready;
    end

    task automatic drive(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic v);
        if (m == 0) begin
            m0_address = a; m0_wdata = d; m0_wsel = s; m0_valid = v;
        end else begin
            m1_address = a; m1_wdata = d; m1_wsel = s; m1_valid = v;
        end
    endtask

    // One transfer: queue the expected response, raise valid, hold until
    // ready, drop after the ready cycle. Called just after a rising edge.
    task automatic xfer(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wsel, input int exp_lat);
        exp_t e;
        int   lat;
        logic rdy;
        e.err   = (addr[31:12] != 20'h0);
        e.chk   = (wsel == 4'h0);
        e.rdata = e.err ? 32'h0 : ref_mem[addr[11:2]];
        if (!e.err)
            for (int b = 0; b < 4; b++)
                if (wsel[b]) ref_mem[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
        if (m == 0) q0.push_back(e); else q1.push_back(e);
        drive(m, addr, wdata, wsel, 1'b1);
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            rdy = (m == 0) ? m0_ready : m1_ready;
        end
        if (!rdy) fail_now("xfer_timeout", $sformatf("master %0d no ready in 40 cycles", m));
        else if (exp_lat > 0) check($sformatf("m%0d_latency", m), 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        drive(m, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic check_log(input string name, input int exp[]);
        check({name, "_count"}, 32'(serve_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < serve_log.size(); i++)
            check($sformatf("%s[%0d]", name, i), 32'(serve_log[i]), 32'(exp[i]));
    endtask

    function automatic logic [31:0] rand_addr(input logic [31:0] base);
        logic [31:0] a;
        a = base | {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a[];
        int c0, c1, n, gap;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0);
        f_m0_address = 32'h0; f_m0_wdata = 32'h0; f_m0_wsel = 4'h0; f_m0_valid = 1'b0;
        f_m1_address = 32'h0; f_m1_wdata = 32'h0; f_m1_wsel = 4'h0; f_m1_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_valid", {31'h0, ram_valid}, 32'h0);
        check("rst_readies", {30'h0, m0_ready, m1_ready}, 32'h0);
        check("rst_ram_address", ram_address, 32'h0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ties after reset (prio 0): m0, m1, then m0, m1 again; after a lone
        // m0 transfer the next tie goes to m1.
        serve_log.delete();
        fork
            xfer(0, 32'h200, 32'h0, 4'h0, 3);
            xfer(1, 32'h600, 32'h0, 4'h0, 7);
        join
        fork
            xfer(0, 32'h204, 32'h0, 4'h0, 3);
            xfer(1, 32'h604, 32'h0, 4'h0, 7);
        join
        xfer(0, 32'h208, 32'h0, 4'h0, 3);
        fork
            xfer(0, 32'h20C, 32'h0, 4'h0, 7);
            xfer(1, 32'h60C, 32'h0, 4'h0, 3);
        join
        exp_a = '{0, 1, 0, 1, 0, 1, 0};
        check_log("tie_order", exp_a);

        // Write from m1, read back by m0.
        xfer(1, 32'h100, 32'hDEADBEEF, 4'hF, 3);
        xfer(0, 32'h100, 32'h0, 4'h0, 3);

        // Byte-lane write merge.
        xfer(1, 32'h104, 32'h11223344, 4'hF, 3);
        xfer(1, 32'h104, 32'h0000AB00, 4'b0010, 3);
        xfer(0, 32'h104, 32'h0, 4'h0, 3);
        check("byte_merge_ref", ref_mem[10'h041], 32'h1122AB44);

        // Back-to-back m0 reads: exactly one ram_valid=0 cycle between them.
        fork
            begin
                xfer(0, 32'h100, 32'h0, 4'h0, 3);
                xfer(0, 32'h104, 32'h0, 4'h0, 3);
            end
            begin
                n = 0;
                gap = 0;
                do begin @(negedge clk); n++; end while (!m0_ready && n < 30);
                do begin
                    @(negedge clk);
                    n++;
                    if (!ram_valid) gap++;
                end while (!m0_ready && n < 60);
                check("b2b_bubble_cycles", 32'(gap), 32'd1);
            end
        join

        // Fixed priority: both hold read requests; m1 takes every grant.
        f_m0_address = 32'h10; f_m0_valid = 1'b1;
        f_m1_address = 32'h20; f_m1_valid = 1'b1;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (f_m0_ready) c0++;
            if (f_m1_ready) c1++;
            if (f_m1_ready) check("fp_m1_rdata", f_m1_rdata, 32'h20 ^ 32'hA5A5_0000);
        end
        @(posedge clk);
        #1;
        f_m0_valid = 1'b0;
        f_m1_valid = 1'b0;
        check("fp_m0_starved", 32'(c0), 32'd0);
        check("fp_m1_grants", 32'(c1), 32'd10);

        // Random concurrent traffic, disjoint address regions per master.
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if ($urandom_range(0, 1) == 0)
                    xfer(0, rand_addr(32'h000), 32'h0, 4'h0, 0);
                else
                    xfer(0, rand_addr(32'h000), $urandom, 4'($urandom_range(1, 15)), 0);
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if ($urandom_range(0, 1) == 0)
                    xfer(1, rand_addr(32'h400), 32'h0, 4'h0, 0);
                else
                    xfer(1, rand_addr(32'h400), $urandom, 4'($urandom_range(1, 15)), 0);
            end
        join

        // Reset while m1 is granted with ram_valid high.
        drive(1, 32'h500, 32'h0, 4'h0, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!ram_valid && n < 10);
        check("abort_reached_grant", {31'h0, ram_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ram_valid", {31'h0, ram_valid}, 32'h0);
        check("abort_ram_bus", ram_address | ram_wdata | {28'h0, ram_wsel}, 32'h0);
        check("abort_m1_outputs", m1_rdata | {30'h0, m1_ready, m1_error}, 32'h0);
        check("abort_m0_outputs", m0_rdata | {30'h0, m0_ready, m0_error}, 32'h0);
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        xfer(1, 32'h500, 32'h0, 4'h0, 3);
        xfer(0, 32'h100, 32'h0, 4'h0, 3);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
